// File: rtl/asrv32_clint_pkg.sv
// asrv32_clint_pkg
// Shared definitions for the asrv32 core-local interruptor (CLINT):
//   - byte offsets of the memory-mapped registers inside the CLINT window
//   - the IDLE/RESP encoding of the bus handshake state machine
//   - a byte-masked 32-bit merge used by every write path
package asrv32_clint_pkg;

    localparam logic [15:0] CLINT_MSIP_OFF        = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_LO_OFF = 16'h4000;
    localparam logic [15:0] CLINT_MTIMECMP_HI_OFF = 16'h4004;
    localparam logic [15:0] CLINT_MTIME_LO_OFF    = 16'hBFF8;
    localparam logic [15:0] CLINT_MTIME_HI_OFF    = 16'hBFFC;

    typedef enum logic {
        CLINT_IDLE = 1'b0,
        CLINT_RESP = 1'b1
    } clint_state_e;

    // Bytes whose mask bit is set take the write data, the rest keep the old value.
    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_val,
        input logic [31:0] wdata,
        input logic [3:0]  wmask
    );
        logic [31:0] merged;
        merged = old_val;
        for (int i = 0; i < 4; i++) begin
            if (wmask[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/asrv32_clint.sv
// asrv32_clint
// Core-local interruptor for the asrv32 core. Holds msip and a mirror of
// mtimecmp, and forwards mtime/mtimecmp writes to asrv32_csr as one-cycle
// write pulses carrying the full new 64-bit value.
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_stb, i_wr, i_addr,
//   i_wdata, i_wmask        bus request (sampled in IDLE only)
//   o_ack, o_rdata, o_err   registered single-cycle response
//   i_mtime                 live mtime from asrv32_csr
//   o_mtime_wr_en/_din      mtime write pulse and value
//   o_mtimecmp_wr_en/_din   mtimecmp write pulse and value
//   o_software_interrupt    msip bit 0
module asrv32_clint
    import asrv32_clint_pkg::*;
#(
    parameter logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF,
    parameter logic        MSIP_RESET     = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stb,
    input  logic        i_wr,
    input  logic [15:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_wmask,
    output logic        o_ack,
    output logic [31:0] o_rdata,
    output logic        o_err,
    input  logic [63:0] i_mtime,
    output logic        o_mtime_wr_en,
    output logic [63:0] o_mtime_din,
    output logic        o_mtimecmp_wr_en,
    output logic [63:0] o_mtimecmp_din,
    output logic        o_software_interrupt
);

    clint_state_e state_q, state_d;
    logic         ack_q, ack_d;
    logic         err_q, err_d;
    logic [31:0]  rdata_q, rdata_d;
    logic         mtime_wr_en_q, mtime_wr_en_d;
    logic [63:0]  mtime_din_q, mtime_din_d;
    logic         mtimecmp_wr_en_q, mtimecmp_wr_en_d;
    logic [63:0]  mtimecmp_din_q, mtimecmp_din_d;
    logic         msip_q, msip_d;
    logic [63:0]  mtimecmp_q, mtimecmp_d;
    logic [31:0]  snap_q, snap_d;
    logic         snap_valid_q, snap_valid_d;

    // The whole request is decoded on the sample edge in IDLE; the response
    // registers then present it during the single RESP cycle. Every response
    // field defaults to 0 so it is only non-zero while o_ack is high.
    always_comb begin
        state_d          = state_q;
        ack_d            = 1'b0;
        err_d            = 1'b0;
        rdata_d          = 32'h0;
        mtime_wr_en_d    = 1'b0;
        mtime_din_d      = mtime_din_q;
        mtimecmp_wr_en_d = 1'b0;
        mtimecmp_din_d   = mtimecmp_din_q;
        msip_d           = msip_q;
        mtimecmp_d       = mtimecmp_q;
        snap_d           = snap_q;
        snap_valid_d     = snap_valid_q;

        case (state_q)
            CLINT_IDLE: begin
                if (i_stb) begin
                    state_d = CLINT_RESP;
                    ack_d   = 1'b1;
                    if (i_addr[1:0] != 2'b00) begin
                        err_d = 1'b1;
                    end else begin
                        case (i_addr)
                            CLINT_MSIP_OFF: begin
                                if (i_wr) begin
                                    if (i_wmask[0]) begin
                                        msip_d = i_wdata[0];
                                    end
                                end else begin
                                    rdata_d = {31'h0, msip_q};
                                end
                            end
                            CLINT_MTIMECMP_LO_OFF: begin
                                if (i_wr) begin
                                    mtimecmp_d       = {mtimecmp_q[63:32],
                                                        byte_merge(mtimecmp_q[31:0], i_wdata, i_wmask)};
                                    mtimecmp_wr_en_d = 1'b1;
                                    mtimecmp_din_d   = mtimecmp_d;
                                end else begin
                                    rdata_d = mtimecmp_q[31:0];
                                end
                            end
                            CLINT_MTIMECMP_HI_OFF: begin
                                if (i_wr) begin
                                    mtimecmp_d       = {byte_merge(mtimecmp_q[63:32], i_wdata, i_wmask),
                                                        mtimecmp_q[31:0]};
                                    mtimecmp_wr_en_d = 1'b1;
                                    mtimecmp_din_d   = mtimecmp_d;
                                end else begin
                                    rdata_d = mtimecmp_q[63:32];
                                end
                            end
                            CLINT_MTIME_LO_OFF: begin
                                if (i_wr) begin
                                    mtime_wr_en_d = 1'b1;
                                    mtime_din_d   = {i_mtime[63:32],
                                                     byte_merge(i_mtime[31:0], i_wdata, i_wmask)};
                                    snap_valid_d  = 1'b0;
                                end else begin
                                    // Capture the high half so a following high read
                                    // is consistent with this low read across a carry.
                                    rdata_d      = i_mtime[31:0];
                                    snap_d       = i_mtime[63:32];
                                    snap_valid_d = 1'b1;
                                end
                            end
                            CLINT_MTIME_HI_OFF: begin
                                if (i_wr) begin
                                    mtime_wr_en_d = 1'b1;
                                    mtime_din_d   = {byte_merge(i_mtime[63:32], i_wdata, i_wmask),
                                                     i_mtime[31:0]};
                                    snap_valid_d  = 1'b0;
                                end else begin
                                    rdata_d      = snap_valid_q ? snap_q : i_mtime[63:32];
                                    snap_valid_d = 1'b0;
                                end
                            end
                            default: begin
                                err_d = 1'b1;
                            end
                        endcase
                    end
                end
            end
            CLINT_RESP: begin
                state_d = CLINT_IDLE;
            end
            default: begin
                state_d = CLINT_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q          <= CLINT_IDLE;
            ack_q            <= 1'b0;
            err_q            <= 1'b0;
            rdata_q          <= 32'h0;
            mtime_wr_en_q    <= 1'b0;
            mtime_din_q      <= 64'h0;
            mtimecmp_wr_en_q <= 1'b0;
            mtimecmp_din_q   <= 64'h0;
            msip_q           <= MSIP_RESET;
            mtimecmp_q       <= MTIMECMP_RESET;
            snap_q           <= 32'h0;
            snap_valid_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            ack_q            <= ack_d;
            err_q            <= err_d;
            rdata_q          <= rdata_d;
            mtime_wr_en_q    <= mtime_wr_en_d;
            mtime_din_q      <= mtime_din_d;
            mtimecmp_wr_en_q <= mtimecmp_wr_en_d;
            mtimecmp_din_q   <= mtimecmp_din_d;
            msip_q           <= msip_d;
            mtimecmp_q       <= mtimecmp_d;
            snap_q           <= snap_d;
            snap_valid_q     <= snap_valid_d;
        end
    end

    // A reset raised during the RESP cycle must swallow the response that is
    // already sitting in the registers, so the strobes are masked by i_rst.
    assign o_ack                = ack_q & ~i_rst;
    assign o_err                = err_q & ~i_rst;
    assign o_rdata              = i_rst ? 32'h0 : rdata_q;
    assign o_mtime_wr_en        = mtime_wr_en_q & ~i_rst;
    assign o_mtimecmp_wr_en     = mtimecmp_wr_en_q & ~i_rst;
    assign o_mtime_din          = mtime_din_q;
    assign o_mtimecmp_din       = mtimecmp_din_q;
    assign o_software_interrupt = msip_q;

endmodule

// File: tb/tb_asrv32_clint.sv
// tb_asrv32_clint
// Self-checking bench for asrv32_clint. Each scenario task drives a table of
// bus transactions, pushes the expected response into a scoreboard queue as
// the request is driven, and pops/compares it once the DUT acknowledges.
module tb_asrv32_clint;

    logic        i_clk;
    logic        i_rst;
    logic        i_stb;
    logic        i_wr;
    logic [15:0] i_addr;
    logic [31:0] i_wdata;
    logic [3:0]  i_wmask;
    logic        o_ack;
    logic [31:0] o_rdata;
    logic        o_err;
    logic [63:0] i_mtime;
    logic        o_mtime_wr_en;
    logic [63:0] o_mtime_din;
    logic        o_mtimecmp_wr_en;
    logic [63:0] o_mtimecmp_din;
    logic        o_software_interrupt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [63:0] mtime;
        logic        err;
        logic [31:0] rdata;
        logic        mt_we;
        logic [63:0] mt_din;
        logic        cmp_we;
        logic [63:0] cmp_din;
        logic        irq;
    } txn_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        logic        mt_we;
        logic [63:0] mt_din;
        logic        cmp_we;
        logic [63:0] cmp_din;
        logic        ack_next;
        logic        we_next;
    } obs_t;

    txn_t        exp_q[$];
    logic [63:0] last_mt_din;
    logic [63:0] last_cmp_din;

    asrv32_clint dut (
        .i_clk                (i_clk),
        .i_rst                (i_rst),
        .i_stb                (i_stb),
        .i_wr                 (i_wr),
        .i_addr               (i_addr),
        .i_wdata              (i_wdata),
        .i_wmask              (i_wmask),
        .o_ack                (o_ack),
        .o_rdata              (o_rdata),
        .o_err                (o_err),
        .i_mtime              (i_mtime),
        .o_mtime_wr_en        (o_mtime_wr_en),
        .o_mtime_din          (o_mtime_din),
        .o_mtimecmp_wr_en     (o_mtimecmp_wr_en),
        .o_mtimecmp_din       (o_mtimecmp_din),
        .o_software_interrupt (o_software_interrupt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic apply_reset();
        @(negedge i_clk);
        i_rst = 1'b1;
        i_stb = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst        = 1'b0;
        last_mt_din  = 64'h0;
        last_cmp_din = 64'h0;
    endtask

    // Din outputs hold their last value when no write pulse is expected.
    task automatic push_expected(input txn_t t);
        txn_t e;
        e = t;
        if (e.mt_we) last_mt_din = e.mt_din;
        else         e.mt_din    = last_mt_din;
        if (e.cmp_we) last_cmp_din = e.cmp_din;
        else          e.cmp_din    = last_cmp_din;
        exp_q.push_back(e);
    endtask

    // Drives one request and captures the response; lat counts cycles from
    // the sample edge until o_ack, bounded so a dead DUT cannot hang the run.
    task automatic bus_access(input txn_t t, output int lat, output obs_t obs);
        @(negedge i_clk);
        i_stb   = 1'b1;
        i_wr    = t.wr;
        i_addr  = t.addr;
        i_wdata = t.wdata;
        i_wmask = t.wmask;
        i_mtime = t.mtime;
        @(posedge i_clk);
        #1;
        i_stb = 1'b0;
        lat   = 1;
        while (o_ack !== 1'b1 && lat < 6) begin
            @(posedge i_clk);
            #1;
            lat++;
        end
        obs.err     = o_err;
        obs.rdata   = o_rdata;
        obs.mt_we   = o_mtime_wr_en;
        obs.mt_din  = o_mtime_din;
        obs.cmp_we  = o_mtimecmp_wr_en;
        obs.cmp_din = o_mtimecmp_din;
        @(posedge i_clk);
        #1;
        obs.ack_next = o_ack;
        obs.we_next  = o_mtime_wr_en | o_mtimecmp_wr_en;
    endtask

    task automatic test_reset();
        txn_t tbl[2];
        txn_t e;
        obs_t obs;
        int   lat;
        apply_reset();
        checks++;
        if ({o_ack, o_err, o_rdata, o_mtime_wr_en, o_mtimecmp_wr_en, o_mtime_din,
             o_mtimecmp_din, o_software_interrupt} !== 164'h0) begin
            failures++;
            $display("[TB] FAIL reset_outputs got ack=%b err=%b rdata=%h mwe=%b cwe=%b mdin=%h cdin=%h irq=%b want all zero",
                     o_ack, o_err, o_rdata, o_mtime_wr_en, o_mtimecmp_wr_en, o_mtime_din,
                     o_mtimecmp_din, o_software_interrupt);
        end
        tbl[0] = '{1'b0, 16'h4000, 32'h0, 4'h0, 64'h0, 1'b0, 32'hFFFF_FFFF, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0};
        tbl[1] = '{1'b0, 16'h4004, 32'h0, 4'h0, 64'h0, 1'b0, 32'hFFFF_FFFF, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0};
        foreach (tbl[i]) begin
            push_expected(tbl[i]);
            bus_access(tbl[i], lat, obs);
            e = exp_q.pop_front();
            checks++;
            if (lat != 1 || obs.ack_next !== 1'b0 || obs.err !== e.err || obs.rdata !== e.rdata) begin
                failures++;
                $display("[TB] FAIL reset_resp[%0d] got lat=%0d err=%b rdata=%h ack_next=%b want lat=1 err=%b rdata=%h ack_next=0",
                         i, lat, obs.err, obs.rdata, obs.ack_next, e.err, e.rdata);
            end
            checks++;
            if (obs.mt_we !== e.mt_we || obs.mt_din !== e.mt_din || obs.cmp_we !== e.cmp_we ||
                obs.cmp_din !== e.cmp_din || obs.we_next !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_wr[%0d] got mwe=%b mdin=%h cwe=%b cdin=%h we_next=%b want mwe=%b mdin=%h cwe=%b cdin=%h we_next=0",
                         i, obs.mt_we, obs.mt_din, obs.cmp_we, obs.cmp_din, obs.we_next,
                         e.mt_we, e.mt_din, e.cmp_we, e.cmp_din);
            end
        end
    endtask

    task automatic test_mtimecmp();
        txn_t tbl[5];
        txn_t e;
        obs_t obs;
        int   lat;
        tbl[0] = '{1'b1, 16'h4000, 32'h1234_5678, 4'b0011, 64'h0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_5678, 1'b0};
        tbl[1] = '{1'b0, 16'h4000, 32'h0, 4'h0, 64'h0, 1'b0, 32'hFFFF_5678, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0};
        tbl[2] = '{1'b1, 16'h4004, 32'hAB00_0000, 4'b1000, 64'h0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b1, 64'hABFF_FFFF_FFFF_5678, 1'b0};
        tbl[3] = '{1'b0, 16'h4004, 32'h0, 4'h0, 64'h0, 1'b0, 32'hABFF_FFFF, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0};
        tbl[4] = '{1'b1, 16'h4000, 32'hDEAD_BEEF, 4'b0000, 64'h0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b1, 64'hABFF_FFFF_FFFF_5678, 1'b0};
        foreach (tbl[i]) begin
            push_expected(tbl[i]);
            bus_access(tbl[i], lat, obs);
            e = exp_q.pop_front();
            checks++;
            if (lat != 1 || obs.ack_next !== 1'b0 || obs.err !== e.err || obs.rdata !== e.rdata) begin
                failures++;
                $display("[TB] FAIL mtimecmp_resp[%0d] got lat=%0d err=%b rdata=%h ack_next=%b want lat=1 err=%b rdata=%h ack_next=0",
                         i, lat, obs.err, obs.rdata, obs.ack_next, e.err, e.rdata);
            end
            checks++;
            if (obs.mt_we !== e.mt_we || obs.mt_din !== e.mt_din || obs.cmp_we !== e.cmp_we ||
                obs.cmp_din !== e.cmp_din || obs.we_next !== 1'b0) begin
                failures++;
                $display("[TB] FAIL mtimecmp_wr[%0d] got mwe=%b mdin=%h cwe=%b cdin=%h we_next=%b want mwe=%b mdin=%h cwe=%b cdin=%h we_next=0",
                         i, obs.mt_we, obs.mt_din, obs.cmp_we, obs.cmp_din, obs.we_next,
                         e.mt_we, e.mt_din, e.cmp_we, e.cmp_din);
            end
        end
    endtask

    task automatic test_mtime_snapshot();
        txn_t tbl[8];
        txn_t e;
        obs_t obs;
        int   lat;
        tbl[0] = '{1'b0, 16'hBFF8, 32'h0, 4'h0, 64'h0000_0001_FFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0};
        tbl[1] = '{1'b0, 16'hBFFC, 32'h0, 4'h0, 64'h0000_0002_0000_0000, 1'b0, 32'h0000_0001, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0};
        tbl[2] = '{1'b0, 16'hBFFC, 32'h0, 4'h0, 64'h0000_0002_0000_0000, 1'b0, 32'h0000_0002, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0};
        tbl[3] = '{1'b1, 16'hBFF8, 32'hAABB_CCDD, 4'b0101, 64'h0000_0005_1122_3344, 1'b0, 32'h0, 1'b1, 64'h0000_0005_11BB_33DD, 1'b0, 64'h0, 1'b0};
        tbl[4] = '{1'b0, 16'hBFF8, 32'h0, 4'h0, 64'h0000_0007_0000_0010, 1'b0, 32'h0000_0010, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0};
        tbl[5] = '{1'b1, 16'hBFFC, 32'h0, 4'b0000, 64'h0000_0007_0000_0020, 1'b0, 32'h0, 1'b1, 64'h0000_0007_0000_0020, 1'b0, 64'h0, 1'b0};
        tbl[6] = '{1'b0, 16'hBFFC, 32'h0, 4'h0, 64'h0000_0009_0000_0000, 1'b0, 32'h0000_0009, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0};
        tbl[7] = '{1'b1, 16'hBFFC, 32'h1234_5678, 4'b1100, 64'hAAAA_AAAA_BBBB_BBBB, 1'b0, 32'h0, 1'b1, 64'h1234_AAAA_BBBB_BBBB, 1'b0, 64'h0, 1'b0};
        foreach (tbl[i]) begin
            push_expected(tbl[i]);
            bus_access(tbl[i], lat, obs);
            e = exp_q.pop_front();
            checks++;
            if (lat != 1 || obs.ack_next !== 1'b0 || obs.err !== e.err || obs.rdata !== e.rdata) begin
                failures++;
                $display("[TB] FAIL mtime_resp[%0d] got lat=%0d err=%b rdata=%h ack_next=%b want lat=1 err=%b rdata=%h ack_next=0",
                         i, lat, obs.err, obs.rdata, obs.ack_next, e.err, e.rdata);
            end
            checks++;
            if (obs.mt_we !== e.mt_we || obs.mt_din !== e.mt_din || obs.cmp_we !== e.cmp_we ||
                obs.cmp_din !== e.cmp_din || obs.we_next !== 1'b0) begin
                failures++;
                $display("[TB] FAIL mtime_wr[%0d] got mwe=%b mdin=%h cwe=%b cdin=%h we_next=%b want mwe=%b mdin=%h cwe=%b cdin=%h we_next=0",
                         i, obs.mt_we, obs.mt_din, obs.cmp_we, obs.cmp_din, obs.we_next,
                         e.mt_we, e.mt_din, e.cmp_we, e.cmp_din);
            end
        end
    endtask

    task automatic test_msip();
        txn_t tbl[5];
        txn_t e;
        obs_t obs;
        int   lat;
        tbl[0] = '{1'b1, 16'h0000, 32'hFFFF_FFFF, 4'hF, 64'h0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1};
        tbl[1] = '{1'b0, 16'h0000, 32'h0, 4'h0, 64'h0, 1'b0, 32'h0000_0001, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1};
        tbl[2] = '{1'b1, 16'h0000, 32'h0000_0000, 4'hF, 64'h0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0};
        tbl[3] = '{1'b1, 16'h0000, 32'hFFFF_FFFF, 4'b1110, 64'h0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0};
        tbl[4] = '{1'b0, 16'h0000, 32'h0, 4'h0, 64'h0, 1'b0, 32'h0000_0000, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0};
        foreach (tbl[i]) begin
            push_expected(tbl[i]);
            bus_access(tbl[i], lat, obs);
            e = exp_q.pop_front();
            checks++;
            if (lat != 1 || obs.ack_next !== 1'b0 || obs.err !== e.err || obs.rdata !== e.rdata) begin
                failures++;
                $display("[TB] FAIL msip_resp[%0d] got lat=%0d err=%b rdata=%h ack_next=%b want lat=1 err=%b rdata=%h ack_next=0",
                         i, lat, obs.err, obs.rdata, obs.ack_next, e.err, e.rdata);
            end
            checks++;
            if (o_software_interrupt !== e.irq || obs.mt_we !== 1'b0 || obs.cmp_we !== 1'b0) begin
                failures++;
                $display("[TB] FAIL msip_irq[%0d] got irq=%b mwe=%b cwe=%b want irq=%b mwe=0 cwe=0",
                         i, o_software_interrupt, obs.mt_we, obs.cmp_we, e.irq);
            end
        end
    endtask

    task automatic test_errors();
        txn_t tbl[5];
        txn_t e;
        obs_t obs;
        int   lat;
        tbl[0] = '{1'b1, 16'h4002, 32'h0000_0000, 4'hF, 64'h0, 1'b1, 32'h0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0};
        tbl[1] = '{1'b0, 16'h8000, 32'h0, 4'h0, 64'h0, 1'b1, 32'h0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0};
        tbl[2] = '{1'b1, 16'hBFF9, 32'h5555_5555, 4'hF, 64'h0000_0003_0000_0004, 1'b1, 32'h0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0};
        tbl[3] = '{1'b1, 16'h0001, 32'hFFFF_FFFF, 4'hF, 64'h0, 1'b1, 32'h0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0};
        tbl[4] = '{1'b0, 16'h4000, 32'h0, 4'h0, 64'h0, 1'b0, 32'hFFFF_5678, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0};
        foreach (tbl[i]) begin
            push_expected(tbl[i]);
            bus_access(tbl[i], lat, obs);
            e = exp_q.pop_front();
            checks++;
            if (lat != 1 || obs.ack_next !== 1'b0 || obs.err !== e.err || obs.rdata !== e.rdata) begin
                failures++;
                $display("[TB] FAIL err_resp[%0d] got lat=%0d err=%b rdata=%h ack_next=%b want lat=1 err=%b rdata=%h ack_next=0",
                         i, lat, obs.err, obs.rdata, obs.ack_next, e.err, e.rdata);
            end
            checks++;
            if (obs.mt_we !== e.mt_we || obs.mt_din !== e.mt_din || obs.cmp_we !== e.cmp_we ||
                obs.cmp_din !== e.cmp_din || o_software_interrupt !== e.irq) begin
                failures++;
                $display("[TB] FAIL err_wr[%0d] got mwe=%b mdin=%h cwe=%b cdin=%h irq=%b want mwe=%b mdin=%h cwe=%b cdin=%h irq=%b",
                         i, obs.mt_we, obs.mt_din, obs.cmp_we, obs.cmp_din, o_software_interrupt,
                         e.mt_we, e.mt_din, e.cmp_we, e.cmp_din, e.irq);
            end
        end
    endtask

    task automatic test_back_to_back();
        int acks_seen;
        apply_reset();
        // Reset raised during the RESP cycle of an mtime write.
        @(negedge i_clk);
        i_stb   = 1'b1;
        i_wr    = 1'b1;
        i_addr  = 16'hBFF8;
        i_wdata = 32'h0000_0042;
        i_wmask = 4'hF;
        i_mtime = 64'h0000_0001_0000_0000;
        @(posedge i_clk);
        #1;
        i_stb = 1'b0;
        i_rst = 1'b1;
        @(negedge i_clk);
        checks++;
        if (o_ack !== 1'b0 || o_mtime_wr_en !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rst_in_resp got ack=%b mwe=%b want ack=0 mwe=0", o_ack, o_mtime_wr_en);
        end
        @(posedge i_clk);
        #1;
        i_rst     = 1'b0;
        acks_seen = 0;
        repeat (3) begin
            @(negedge i_clk);
            if (o_ack === 1'b1 || o_mtime_wr_en === 1'b1) acks_seen++;
        end
        checks++;
        if (acks_seen != 0 || o_mtime_din !== 64'h0) begin
            failures++;
            $display("[TB] FAIL rst_lost_req got late_acks=%0d mdin=%h want late_acks=0 mdin=0",
                     acks_seen, o_mtime_din);
        end
        // Strobe held high: the FSM accepts every other cycle.
        @(negedge i_clk);
        i_stb  = 1'b1;
        i_wr   = 1'b0;
        i_addr = 16'h4004;
        for (int k = 0; k < 8; k++) begin
            @(negedge i_clk);
            checks++;
            if (o_ack !== ((k % 2) == 0) || o_rdata !== (((k % 2) == 0) ? 32'hFFFF_FFFF : 32'h0)) begin
                failures++;
                $display("[TB] FAIL b2b_cycle[%0d] got ack=%b rdata=%h want ack=%b rdata=%h",
                         k, o_ack, o_rdata, ((k % 2) == 0), (((k % 2) == 0) ? 32'hFFFF_FFFF : 32'h0));
            end
        end
        i_stb = 1'b0;
        repeat (2) @(negedge i_clk);
    endtask

    initial begin
        i_rst        = 1'b1;
        i_stb        = 1'b0;
        i_wr         = 1'b0;
        i_addr       = 16'h0;
        i_wdata      = 32'h0;
        i_wmask      = 4'h0;
        i_mtime      = 64'h0;
        last_mt_din  = 64'h0;
        last_cmp_din = 64'h0;

        test_reset();
        test_mtimecmp();
        test_mtime_snapshot();
        test_msip();
        test_errors();
        test_back_to_back();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/asrv32_clint.md
ASRV32_CLINT -- requirements
Module: asrv32_clint

Interface
REQ-001 The parameter MTIMECMP_RESET, default 64'hFFFF_FFFF_FFFF_FFFF, SHALL set the mtimecmp reset value so no timer interrupt fires out of reset.
REQ-002 The parameter MSIP_RESET, default 1'b0, SHALL set the msip reset value.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 i_clk  in  1  core clock; all state changes on its rising edge.
REQ-005 i_rst  in  1  synchronous active-high reset.
REQ-006 i_stb  in  1  bus request strobe, sampled only in IDLE.
REQ-007 i_wr  in  1  1 = write, 0 = read.
REQ-008 i_addr  in  16  byte offset within the CLINT window.
REQ-009 i_wdata  in  32  write data.
REQ-010 i_wmask  in  4  byte write enables; bit n covers i_wdata[8n+7:8n].
REQ-011 o_ack  out  1  single-cycle response strobe.
REQ-012 o_rdata  out  32  read data, valid while o_ack is high.
REQ-013 o_err  out  1  access error, asserted with o_ack.
REQ-014 i_mtime  in  64  live mtime value from asrv32_csr.
REQ-015 o_mtime_wr_en  out  1  one-cycle write pulse to the asrv32_csr mtime register.
REQ-016 o_mtime_din  out  64  new mtime value.
REQ-017 o_mtimecmp_wr_en  out  1  one-cycle write pulse to the asrv32_csr mtimecmp register.
REQ-018 o_mtimecmp_din  out  64  new mtimecmp value.
REQ-019 o_software_interrupt  out  1  equals msip bit 0; drives the software-interrupt input of asrv32_csr.

Function
REQ-020 Address map: 0x0000 msip; 0x4000 mtimecmp[31:0]; 0x4004 mtimecmp[63:32]; 0xBFF8 mtime[31:0]; 0xBFFC mtime[63:32].
REQ-021 FSM states:
  - IDLE: on i_stb, latch the request and go to RESP.
  - RESP: o_ack=1 for exactly one cycle, then return to IDLE.
  - In RESP, i_stb SHALL be ignored (no queueing).
REQ-022 Latency SHALL be exactly one cycle from the i_stb sample edge to o_ack.
  - Back-to-back requests complete at most every 2 cycles.
REQ-023 o_rdata and o_err SHALL be registered and valid only while o_ack=1.
  - o_rdata SHALL be 0 whenever o_ack=0.
REQ-024 Unmapped offset, or i_addr[1:0]!=0, SHALL give o_ack=1, o_err=1, o_rdata=0, and change no state.
REQ-025 Writes SHALL merge byte-wise:
  - Bytes with a mask bit of 0 keep the old value.
  - i_wmask=0 SHALL be a legal no-op write that still acks.
REQ-026 msip SHALL hold only bit 0; bits 31:1 SHALL read as 0 and ignore writes.
REQ-027 The block SHALL keep an internal mtimecmp mirror.
  - A mtimecmp half-write updates the mirror.
  - The same write asserts o_mtimecmp_wr_en for one cycle, coincident with o_ack, with o_mtimecmp_din equal to the full new 64-bit mirror.
REQ-028 mtime writes SHALL merge into i_mtime as sampled on the request edge.
  - The write asserts o_mtime_wr_en for one cycle, coincident with o_ack.
  - Low-half write: o_mtime_din = {sampled hi, merged lo}.
  - High-half write: o_mtime_din = {merged hi, sampled lo}.
REQ-029 Read of mtime[31:0] SHALL return i_mtime[31:0] and snapshot i_mtime[63:32] with snap_valid set to 1.
REQ-030 Read of mtime[63:32] SHALL return the snapshot if snap_valid=1, otherwise live i_mtime[63:32], and SHALL clear snap_valid.
REQ-031 Any mtime write SHALL clear snap_valid.
REQ-032 Reads of msip or mtimecmp SHALL return the internal registers.
REQ-033 Wr-enable outputs SHALL never assert without o_ack, and never for reads or errors.
  - Both wr-enables SHALL be 0 except in the single ack cycle.
REQ-034 o_mtime_din and o_mtimecmp_din SHALL hold their last value while their wr-enable is low.

Reset
REQ-035 On i_rst=1 at a clock edge, the block SHALL enter this state:
  - FSM = IDLE.
  - o_ack=0, o_err=0, o_rdata=0.
  - Both wr-enables = 0, both din outputs = 0.
  - msip = MSIP_RESET.
  - mtimecmp mirror = MTIMECMP_RESET.
  - snap_valid=0.
REQ-036 Reset asserted while in RESP SHALL suppress that ack and any pending wr-enable pulse; the request is lost.
REQ-037 Reset SHALL NOT generate an o_mtimecmp_wr_en pulse; asrv32_csr resets its own copy.

Structure
REQ-038 The shared header SHALL hold the CLINT offset localparams and the IDLE/RESP state encoding.
REQ-039 The block SHALL be one flat module with no sub-modules.
  - An optional helper, asrv32_byte_merge (32-bit masked merge), is allowed.

Verification
REQ-040 Scenario 1 (reset state):
  - Stimulus: reset, then read 0x4000 and 0x4004.
  - Required response: rdata 0xFFFFFFFF both, o_ack one cycle after each stb, wr-enables 0 throughout.
REQ-041 Scenario 2 (mtimecmp low write):
  - Stimulus: write 0x4000 with wdata 0x12345678, wmask 4'b0011.
  - Required response: o_mtimecmp_wr_en pulse with din 0xFFFFFFFF_FFFF5678.
  - Follow-up: read 0x4000 returns 0xFFFF5678.
REQ-042 Scenario 3 (mtime snapshot):
  - Stimulus: i_mtime=0x00000001_FFFFFFFF; read 0xBFF8; i_mtime then becomes 0x00000002_00000000; read 0xBFFC.
  - Required response: returns 0xFFFFFFFF, then 0x00000001.
  - Follow-up: a second read of 0xBFFC returns 0x00000002.
REQ-043 Scenario 4 (msip):
  - Stimulus: write 0x0000 with 0xFFFFFFFF, wmask 4'hF.
  - Required response: o_software_interrupt=1; read returns 0x00000001.
  - Follow-up: write 0 gives o_software_interrupt=0.
REQ-044 Scenario 5 (errors):
  - Stimulus: write 0x4002, then read 0x8000.
  - Required response: each acks with o_err=1, o_rdata=0, no wr-enable.
REQ-045 Scenario 6 (reset and back-to-back):
  - Stimulus: assert i_rst in the RESP cycle of a mtime write.
  - Required response: no o_ack, no o_mtime_wr_en.
  - Stimulus: i_stb held high continuously.
  - Required response: o_ack every second cycle.
